// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM path; the state encoding is also used
// by the LED decoder and must stay 0..4.
package motor_pkg;

    localparam int PWM_STATE_W = 3;

    typedef enum logic [PWM_STATE_W-1:0] {
        ST_OFF = 3'd0,
        ST_L1  = 3'd1,
        ST_L2  = 3'd2,
        ST_L3  = 3'd3,
        ST_L4  = 3'd4
    } speed_state_e;

    function automatic logic [7:0] timer_load(input logic [1:0] sel, input int unsigned step_sec);
        return 8'(32'(sel) * step_sec);
    endfunction

endpackage

// File: rtl/motor_pwm_controller_if.sv
// Button pulses in, speed/timer status and motor PWM out.
interface motor_pwm_controller_if;
    import motor_pkg::*;

    logic                   i_btn_speed;
    logic                   i_btn_timer;
    logic                   i_btn_stop;
    logic [PWM_STATE_W-1:0] o_pwm_state;
    logic                   o_pwm;
    logic [1:0]             o_timer_sel;
    logic [7:0]             o_timer_remain;

    modport master (
        output i_btn_speed, i_btn_timer, i_btn_stop,
        input  o_pwm_state, o_pwm, o_timer_sel, o_timer_remain
    );

    modport slave (
        input  i_btn_speed, i_btn_timer, i_btn_stop,
        output o_pwm_state, o_pwm, o_timer_sel, o_timer_remain
    );

endinterface

// File: rtl/pwm_generator.sv
// Free-running PWM counter with clock divider and registered duty compare.
module pwm_generator #(
    parameter int PWM_DIV    = 1000,
    parameter int PWM_PERIOD = 100,
    parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_pwm
);

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int CNT_W = $clog2(PWM_PERIOD);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (DUTY_W'(r_cnt) < i_duty);
            if (r_div == DIV_W'(PWM_DIV - 1)) begin
                r_div <= '0;
                r_cnt <= (r_cnt == CNT_W'(PWM_PERIOD - 1)) ? '0 : r_cnt + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_pwm_controller.sv
// Speed FSM, auto-off countdown timer and second prescaler driving the PWM generator.
module motor_pwm_controller
    import motor_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int PWM_DIV        = 1000,
    parameter int PWM_PERIOD     = 100,
    parameter int TIMER_STEP_SEC = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    motor_pwm_controller_if.slave  bus
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DUTY_W  = $clog2(PWM_PERIOD + 1);

    speed_state_e     r_state, w_state_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [7:0]       r_remain, w_remain_nxt;
    logic [PRESC_W-1:0] r_presc, w_presc_nxt;
    logic             w_tick;
    logic             w_expire;
    logic [DUTY_W-1:0] w_duty;

    assign w_tick   = (r_sel != '0) && (r_presc == PRESC_W'(CLK_HZ - 1));
    assign w_expire = w_tick && (r_remain == 8'd1);

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_remain_nxt = r_remain;
        w_presc_nxt  = (r_sel == '0 || w_tick) ? '0 : r_presc + 1'b1;

        if (bus.i_btn_stop || w_expire) begin
            w_state_nxt  = ST_OFF;
            w_sel_nxt    = '0;
            w_remain_nxt = '0;
            w_presc_nxt  = '0;
        end else begin
            if (w_tick && r_remain > 8'd1)
                w_remain_nxt = r_remain - 8'd1;
            if (bus.i_btn_speed) begin
                case (r_state)
                    ST_OFF:  w_state_nxt = ST_L1;
                    ST_L1:   w_state_nxt = ST_L2;
                    ST_L2:   w_state_nxt = ST_L3;
                    ST_L3:   w_state_nxt = ST_L4;
                    default: w_state_nxt = ST_OFF;
                endcase
            end
            // Landing in OFF (including the L4 wrap) drops any timer press and clears the timer.
            if (w_state_nxt == ST_OFF) begin
                w_sel_nxt    = '0;
                w_remain_nxt = '0;
                w_presc_nxt  = '0;
            end else if (bus.i_btn_timer) begin
                w_sel_nxt    = r_sel + 2'd1;
                w_remain_nxt = timer_load(w_sel_nxt, TIMER_STEP_SEC);
                w_presc_nxt  = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_OFF;
            r_sel    <= '0;
            r_remain <= '0;
            r_presc  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_remain <= w_remain_nxt;
            r_presc  <= w_presc_nxt;
        end
    end

    assign w_duty = DUTY_W'(32'(r_state) * (PWM_PERIOD / 4));

    pwm_generator #(
        .PWM_DIV    (PWM_DIV),
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_duty  (w_duty),
        .o_pwm   (bus.o_pwm)
    );

    assign bus.o_pwm_state    = r_state;
    assign bus.o_timer_sel    = r_sel;
    assign bus.o_timer_remain = r_remain;

endmodule
